// File: rtl/cpu_datapath_if.sv
// cpu_datapath_if: strobe and status bundle between the CPU controller and the
// register/ALU datapath.
//   master : controller side, drives Enable/Tristate/ALUOp/InstrBus and observes
//            out_data, bus_mon, carry, zero, bus_conflict.
//   slave  : datapath side, the reverse directions.
interface cpu_datapath_if #(
  parameter int WIDTH = 8
);
  logic [6:0]       Enable;       // [3:0] R0-R3 load, [4] A load, [5] ALU execute, [6] OUT load
  logic [5:0]       Tristate;     // [3:0] R0-R3 drive, [4] Y drives, [5] immediate drives
  logic [1:0]       ALUOp;        // 00 add, 01 sub, 10 and, 11 or
  logic [3:0]       InstrBus;     // immediate nibble
  logic [WIDTH-1:0] out_data;     // store/output latch
  logic [WIDTH-1:0] bus_mon;      // current bus value
  logic             carry;        // carry (add) / borrow (sub)
  logic             zero;         // last ALU result was zero
  logic             bus_conflict; // sticky multi-driver indication

  modport master (
    output Enable, Tristate, ALUOp, InstrBus,
    input  out_data, bus_mon, carry, zero, bus_conflict
  );

  modport slave (
    input  Enable, Tristate, ALUOp, InstrBus,
    output out_data, bus_mon, carry, zero, bus_conflict
  );
endinterface

// File: rtl/cpu_datapath.sv
// cpu_datapath: four general registers R0-R3, ALU operand latch A, result latch Y,
// output latch and flags, all joined by a single shared bus. The bus is a
// priority mux standing in for a tristate bus: the lowest-index Tristate source
// wins, and more than one active driver sets a sticky bus_conflict flag.
// Ports:
//   clk       : system clock, every state update on posedge
//   clr       : synchronous active-high reset
//   clearRegs : synchronous register clear from the controller, same effect as clr
//   dp        : cpu_datapath_if.slave strobes in, out_data/bus_mon/flags out
module cpu_datapath #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           clearRegs,
  cpu_datapath_if.slave  dp
);

  localparam int NREG = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } alu_op_e;

  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             conflict_q, conflict_d;

  logic [WIDTH-1:0] bus;
  logic             multi_drive;
  alu_op_e          alu_op;
  logic [WIDTH-1:0] alu_y;
  logic             alu_c;

  // Bus source select: lowest index wins when several drivers are enabled.
  always_comb begin
    bus = '0;
    if      (dp.Tristate[0]) bus = regs_q[0];
    else if (dp.Tristate[1]) bus = regs_q[1];
    else if (dp.Tristate[2]) bus = regs_q[2];
    else if (dp.Tristate[3]) bus = regs_q[3];
    else if (dp.Tristate[4]) bus = y_q;
    else if (dp.Tristate[5]) bus = {{(WIDTH-4){1'b0}}, dp.InstrBus};
  end

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_drive = (dp.Tristate & (dp.Tristate - 6'd1)) != 6'd0;

  assign alu_op = alu_op_e'(dp.ALUOp);

  // ALU always sees the registered A, so a same-cycle A load does not disturb it.
  always_comb begin
    alu_y = '0;
    alu_c = 1'b0;
    case (alu_op)
      OP_ADD: {alu_c, alu_y} = {1'b0, a_q} + {1'b0, bus};
      OP_SUB: begin
        alu_y = a_q - bus;
        alu_c = (a_q < bus);  // borrow
      end
      OP_AND: alu_y = a_q & bus;
      default: alu_y = a_q | bus;
    endcase
  end

  // NOTE: every output of a combinational block gets a default first (here "hold"),
  // so no path through the block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    regs_d     = regs_q;
    a_d        = a_q;
    y_d        = y_q;
    out_d      = out_q;
    carry_d    = carry_q;
    zero_d     = zero_q;
    conflict_d = conflict_q | multi_drive;

    for (int i = 0; i < NREG; i++) begin
      if (dp.Enable[i]) regs_d[i] = bus;
    end
    if (dp.Enable[4]) a_d = bus;
    if (dp.Enable[5]) begin
      y_d     = alu_y;
      carry_d = alu_c;
      zero_d  = (alu_y == '0);
    end
    if (dp.Enable[6]) out_d = bus;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values; blocking here would let one register see another's new value.
  // NOTE: the register file is only four words held in flops, and software relies on
  // R0-R3 reading zero after a clear, so it is reset like every other piece of state.
  always_ff @(posedge clk) begin
    if (clr || clearRegs) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      a_q        <= '0;
      y_q        <= '0;
      out_q      <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
      a_q        <= a_d;
      y_q        <= y_d;
      out_q      <= out_d;
      carry_q    <= carry_d;
      zero_q     <= zero_d;
      conflict_q <= conflict_d;
    end
  end

  assign dp.out_data     = out_q;
  assign dp.bus_mon      = bus;
  assign dp.carry        = carry_q;
  assign dp.zero         = zero_q;
  assign dp.bus_conflict = conflict_q;

endmodule

// File: tb/tb_cpu_datapath.sv
// tb_cpu_datapath: directed controller sequences followed by random strobes, all
// checked against a behavioural model of the datapath's architectural state.
module tb_cpu_datapath;

  localparam int WIDTH = 8;
  localparam int MASK  = (1 << WIDTH) - 1;

  logic clk;
  logic clr;
  logic clear_regs;

  cpu_datapath_if #(.WIDTH(WIDTH)) ifc ();

  cpu_datapath #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .clr       (clr),
    .clearRegs (clear_regs),
    .dp        (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architectural state as plain integers.
  int unsigned m_r [4];
  int unsigned m_a, m_y, m_out;
  bit          m_c, m_z, m_conf;

  int n_checks;
  int n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Value on the bus: first enabled source in index order, else zero.
  function automatic int unsigned model_bus(input logic [5:0] ts, input logic [3:0] imm);
    for (int i = 0; i < 6; i++) begin
      if (ts[i]) begin
        if (i < 4) return m_r[i];
        if (i == 4) return m_y;
        return int'(imm);
      end
    end
    return 0;
  endfunction

  // One clock cycle: apply strobes, check bus, advance the model, check outputs.
  task automatic cycle(input bit rst, input bit crg, input logic [6:0] en,
                       input logic [5:0] ts, input logic [1:0] op,
                       input logic [3:0] imm, input string tag);
    int unsigned b, s;
    int unsigned nr [4];
    int unsigned na, ny, nout;
    bit nc, nz, nconf;
    clr          = rst;
    clear_regs   = crg;
    ifc.Enable   = en;
    ifc.Tristate = ts;
    ifc.ALUOp    = op;
    ifc.InstrBus = imm;
    #1;
    b = model_bus(ts, imm);
    check({tag, "_bus"}, 32'(ifc.bus_mon), b);

    nr = m_r; na = m_a; ny = m_y; nout = m_out;
    nc = m_c; nz = m_z; nconf = m_conf;
    if (rst || crg) begin
      foreach (nr[i]) nr[i] = 0;
      na = 0; ny = 0; nout = 0; nc = 0; nz = 0; nconf = 0;
    end else begin
      if (en[5]) begin
        case (op)
          2'd0: begin s = m_a + b; ny = s & MASK; nc = (s > MASK); end
          2'd1: begin ny = (m_a - b) & MASK; nc = (m_a < b); end
          2'd2: begin ny = m_a & b; nc = 0; end
          default: begin ny = m_a | b; nc = 0; end
        endcase
        nz = (ny == 0);
      end
      for (int i = 0; i < 4; i++) if (en[i]) nr[i] = b;
      if (en[4]) na = b;
      if (en[6]) nout = b;
      nconf = m_conf || ($countones(ts) > 1);
    end

    @(posedge clk);
    #1;
    m_r = nr; m_a = na; m_y = ny; m_out = nout;
    m_c = nc; m_z = nz; m_conf = nconf;
    check({tag, "_out"},  32'(ifc.out_data),     m_out);
    check({tag, "_carry"}, 32'(ifc.carry),       32'(m_c));
    check({tag, "_zero"},  32'(ifc.zero),        32'(m_z));
    check({tag, "_conf"},  32'(ifc.bus_conflict), 32'(m_conf));
  endtask

  task automatic load(input int rd, input logic [3:0] imm);
    cycle(0, 0, 7'(1) << rd, 6'b100000, 2'd0, imm, "load");
  endtask

  task automatic move(input int rs, input int rd);
    cycle(0, 0, 7'(1) << rd, 6'(1) << rs, 2'd0, 4'h0, "move");
  endtask

  // Controller ALU sequence: A<=Rs, Y<=A op Rd, Rd<=Y.
  task automatic alu(input int rs, input int rd, input logic [1:0] op);
    cycle(0, 0, 7'b0010000, 6'(1) << rs, 2'd0, 4'h0, "alu_in");
    cycle(0, 0, 7'b0100000, 6'(1) << rd, op,   4'h0, "alu_exec");
    cycle(0, 0, 7'(1) << rd, 6'b010000,  2'd0, 4'h0, "alu_out");
  endtask

  // Drive a register onto the bus for a cycle and compare with a fixed value.
  task automatic peek(input int idx, input logic [31:0] exp, input string tag);
    cycle(0, 0, 7'd0, 6'(1) << idx, 2'd0, 4'h0, "peek");
    check(tag, 32'(ifc.bus_mon), exp);
  endtask

  initial begin
    logic [6:0] r_en;
    logic [5:0] r_ts;
    int         sel;
    n_checks = 0;
    n_fail   = 0;
    foreach (m_r[i]) m_r[i] = 0;
    m_a = 0; m_y = 0; m_out = 0; m_c = 0; m_z = 0; m_conf = 0;
    clr = 1'b1; clear_regs = 1'b0;
    ifc.Enable = '0; ifc.Tristate = '0; ifc.ALUOp = '0; ifc.InstrBus = '0;
    @(posedge clk);
    #1;

    // Reset and immediate load.
    cycle(1, 0, 7'd0, 6'd0, 2'd0, 4'h0, "reset");
    check("rst_out", 32'(ifc.out_data), 32'h0);
    check("rst_carry", 32'(ifc.carry), 32'h0);
    load(2, 4'h9);
    peek(2, 32'h09, "t1_r2");
    check("t1_conf", 32'(ifc.bus_conflict), 32'h0);

    // Build R0=F0, R1=20, then add with carry out.
    load(0, 4'h8); load(1, 4'h8);
    alu(0, 1, 2'd0);
    load(0, 4'h0);
    alu(0, 1, 2'd1);
    move(1, 0);
    load(2, 4'h8); load(3, 4'h8);
    alu(2, 3, 2'd0);
    alu(3, 3, 2'd0);
    move(3, 1);
    peek(0, 32'hF0, "t2_r0");
    peek(1, 32'h20, "t2_r1");
    alu(0, 1, 2'd0);
    peek(1, 32'h10, "t2_sum");
    check("t2_carry", 32'(ifc.carry), 32'h1);
    check("t2_zero",  32'(ifc.zero),  32'h0);

    // Subtract with borrow, then equal operands give zero.
    load(0, 4'h3); load(1, 4'h5);
    alu(0, 1, 2'd1);
    peek(1, 32'hFE, "t3_diff");
    check("t3_borrow", 32'(ifc.carry), 32'h1);
    load(0, 4'h7); load(1, 4'h7);
    alu(0, 1, 2'd1);
    peek(1, 32'h00, "t3_zero_res");
    check("t3_zero", 32'(ifc.zero),  32'h1);
    check("t3_nob",  32'(ifc.carry), 32'h0);

    // R3=A5 by doubling and OR, then store to out_data.
    load(3, 4'hA);
    for (int i = 0; i < 4; i++) alu(3, 3, 2'd0);
    load(2, 4'h5);
    alu(2, 3, 2'd3);
    peek(3, 32'hA5, "t4_r3");
    cycle(0, 0, 7'b1000000, 6'b001000, 2'd0, 4'h0, "store");
    check("t4_out", 32'(ifc.out_data), 32'hA5);
    peek(2, 32'h05, "t4_r2_kept");

    // Two drivers: lowest index wins, conflict is sticky until clearRegs.
    load(0, 4'h1); load(1, 4'h2);
    cycle(0, 0, 7'b0000100, 6'b000011, 2'd0, 4'h0, "conflict");
    check("t5_conf", 32'(ifc.bus_conflict), 32'h1);
    peek(2, 32'h01, "t5_r2");
    check("t5_conf_hold", 32'(ifc.bus_conflict), 32'h1);
    cycle(0, 1, 7'd0, 6'd0, 2'd0, 4'h0, "clear_regs");
    check("t5_conf_clr", 32'(ifc.bus_conflict), 32'h0);
    for (int i = 0; i < 4; i++) peek(i, 32'h0, "t5_reg_clr");

    // Clear beats a same-cycle load; reset mid-ALU sequence.
    cycle(0, 1, 7'b0000001, 6'b100000, 2'd0, 4'hC, "clr_vs_load");
    peek(0, 32'h0, "t6_r0");
    load(0, 4'h3); load(1, 4'h4);
    cycle(0, 0, 7'b0010000, 6'b000001, 2'd0, 4'h0, "t6_in");
    cycle(0, 0, 7'b0100000, 6'b000010, 2'd0, 4'h0, "t6_exec");
    cycle(1, 0, 7'd0, 6'd0, 2'd0, 4'h0, "t6_clr");
    cycle(0, 0, 7'b0000010, 6'b010000, 2'd0, 4'h0, "t6_outp");
    peek(1, 32'h0, "t6_r1");
    check("t6_carry", 32'(ifc.carry), 32'h0);
    check("t6_zero",  32'(ifc.zero),  32'h0);

    // Random strobes against the model.
    for (int n = 0; n < 400; n++) begin
      r_en = 7'($urandom);
      sel  = int'($urandom_range(0, 9));
      if (sel < 6)       r_ts = 6'(1) << sel;
      else if (sel == 6) r_ts = 6'd0;
      else               r_ts = 6'($urandom);
      cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 39) == 0), r_en, r_ts,
            2'($urandom), 4'($urandom), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
